// File: rtl/maxnet_input_loader_if.sv
// Handshake and operand bundle between the loader, its upstream feeder,
// the Maxnet core and the result consumer.
interface maxnet_input_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        mx_start;
  logic [31:0] mx_epsilon;
  logic [31:0] mx_a1;
  logic [31:0] mx_a2;
  logic [31:0] mx_a3;
  logic [31:0] mx_a4;
  logic        mx_finish;
  logic [31:0] mx_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_timeout;

  modport master (
    output in_valid, in_data, mx_finish, mx_out, res_ready,
    input  in_ready, mx_start, mx_epsilon, mx_a1, mx_a2, mx_a3,
    input  mx_a4, res_valid, res_data, res_timeout
  );

  modport slave (
    input  in_valid, in_data, mx_finish, mx_out, res_ready,
    output in_ready, mx_start, mx_epsilon, mx_a1, mx_a2, mx_a3,
    output mx_a4, res_valid, res_data, res_timeout
  );
endinterface

// File: rtl/maxnet_input_loader.sv
// Collects epsilon + four activations, kicks the Maxnet core and
// returns its winner (or a timeout marker) on a result handshake.
module maxnet_input_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned START_CYCLES   = 1
) (
  input logic                  clk,
  input logic                  rst,
  maxnet_input_loader_if.slave bus
);
  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_RESULT
  } state_t;

  localparam bit          TMO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST   =
    TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [31:0] START_LAST = 32'(START_CYCLES - 1);

  state_t      state;
  logic [2:0]  word_cnt;
  logic [31:0] wait_cnt;

  logic xfer;
  assign xfer = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_LOAD;
      word_cnt        <= '0;
      wait_cnt        <= '0;
      bus.in_ready    <= 1'b0;
      bus.mx_start    <= 1'b0;
      bus.mx_epsilon  <= '0;
      bus.mx_a1       <= '0;
      bus.mx_a2       <= '0;
      bus.mx_a3       <= '0;
      bus.mx_a4       <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_timeout <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          bus.in_ready <= 1'b1;
          if (xfer) begin
            unique case (word_cnt)
              3'd0:    bus.mx_epsilon <= bus.in_data;
              3'd1:    bus.mx_a1      <= bus.in_data;
              3'd2:    bus.mx_a2      <= bus.in_data;
              3'd3:    bus.mx_a3      <= bus.in_data;
              default: bus.mx_a4      <= bus.in_data;
            endcase
            if (word_cnt == 3'd4) begin
              word_cnt     <= '0;
              wait_cnt     <= '0;
              bus.in_ready <= 1'b0;
              bus.mx_start <= 1'b1;
              state        <= S_START;
            end else begin
              word_cnt <= word_cnt + 3'd1;
            end
          end
        end
        S_START: begin
          if (wait_cnt == START_LAST) begin
            bus.mx_start <= 1'b0;
            wait_cnt     <= '0;
            state        <= S_WAIT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 32'd1;
          // finish has priority over a coincident timeout
          if (bus.mx_finish) begin
            bus.res_data    <= bus.mx_out;
            bus.res_timeout <= 1'b0;
            bus.res_valid   <= 1'b1;
            state           <= S_RESULT;
          end else if (TMO_EN && wait_cnt == TMO_LAST) begin
            bus.res_data    <= '0;
            bus.res_timeout <= 1'b1;
            bus.res_valid   <= 1'b1;
            state           <= S_RESULT;
          end
        end
        default: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= S_LOAD;
          end
        end
      endcase
    end
  end
endmodule
